// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory req/gnt/rvalid bus between MEM stage and data RAM
interface mem_access_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_gnt;
  logic              dmem_rvalid;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: data-memory access FSM, stall and writeback (optional MEM_TIMEOUT_EN watchdog)
module mem_access_stage #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_mem_re,
  input  logic              mem_mem_we,
  input  logic [ADDR_W-1:0] mem_mem_addr,
  input  logic [DATA_W-1:0] mem_store_data,
  input  logic              mem_regfile_we,
  input  logic [REG_AW-1:0] mem_regfile_waddr,
  input  logic [DATA_W-1:0] mem_data,
  mem_access_stage_if.master dmem,
  output logic              stall_o,
  output logic              wb_regfile_we,
  output logic [REG_AW-1:0] wb_regfile_waddr,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic              wb_we_q, wb_we_d;
  logic [REG_AW-1:0] wb_waddr_q, wb_waddr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              stall_c;
  logic              req_c;
  logic              err_c;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
`endif

  // Next-state, latched access fields, writeback fields and combinational bus/stall outputs
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    rf_we_d    = rf_we_q;
    rf_waddr_d = rf_waddr_q;
    wb_we_d    = wb_we_q;
    wb_waddr_d = wb_waddr_q;
    wb_data_d  = wb_data_q;
    stall_c    = 1'b0;
    req_c      = 1'b0;
    err_c      = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (mem_mem_re | mem_mem_we) begin
          // Store wins when both are set; the writeback slot becomes a bubble
          stall_c    = 1'b1;
          addr_d     = mem_mem_addr;
          wdata_d    = mem_store_data;
          we_d       = mem_mem_we;
          rf_we_d    = mem_regfile_we;
          rf_waddr_d = mem_regfile_waddr;
          wb_we_d    = 1'b0;
          state_d    = REQ;
`ifdef MEM_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end else begin
          wb_we_d    = mem_regfile_we;
          wb_waddr_d = mem_regfile_waddr;
          wb_data_d  = mem_data;
        end
      end
      REQ: begin
        stall_c = 1'b1;
        req_c   = 1'b1;
        if (dmem.dmem_gnt) begin
          state_d = we_q ? RESP : WAIT;
        end
      end
      WAIT: begin
        stall_c = 1'b1;
        if (dmem.dmem_rvalid) begin
          wb_we_d    = rf_we_q;
          wb_waddr_d = rf_waddr_q;
          wb_data_d  = dmem.dmem_rdata;
          state_d    = RESP;
        end
      end
      RESP: begin
        // Upstream advances this cycle; its inputs are not yet the next instruction
        wb_we_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef MEM_TIMEOUT_EN
    if (state_q == REQ || state_q == WAIT) begin
      cnt_d = cnt_q + 1'b1;
      // Abandon the access; a grant arriving in this cycle is not seen since req is withdrawn
      if (cnt_q == CNT_LIM && !(state_q == WAIT && dmem.dmem_rvalid)) begin
        err_c     = 1'b1;
        req_c     = 1'b0;
        wb_we_d   = 1'b0;
        wb_data_d = '0;
        state_d   = RESP;
      end
    end
`endif
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      wb_we_q    <= 1'b0;
      wb_waddr_q <= '0;
      wb_data_q  <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      wb_we_q    <= wb_we_d;
      wb_waddr_q <= wb_waddr_d;
      wb_data_q  <= wb_data_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  // Combinational controls are forced low while reset is held so a mid-access reset drops req at once
  assign stall_o          = stall_c & ~rst;
  assign dmem.dmem_req    = req_c & ~rst;
  assign dmem.dmem_we     = we_q;
  assign dmem.dmem_addr   = addr_q;
  assign dmem.dmem_wdata  = wdata_q;
  assign wb_regfile_we    = wb_we_q;
  assign wb_regfile_waddr = wb_waddr_q;
  assign wb_data          = wb_data_q;
`ifdef MEM_TIMEOUT_EN
  assign mem_err          = err_c & ~rst;
`else
  assign mem_err          = 1'b0 & err_c;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - transaction-timeline reference model and per-cycle compare for mem_access_stage
`timescale 1ns/1ps
module tb_mem_access_stage;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          re = 1'b0, we = 1'b0, rf_we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] sdata = '0, mdata = '0;
  logic [RW-1:0] waddr = '0;
  logic          stall_o, wb_regfile_we, mem_err;
  logic [RW-1:0] wb_regfile_waddr;
  logic [DW-1:0] wb_data;

  mem_access_stage_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_access_stage #(.ADDR_W(AW), .DATA_W(DW), .REG_AW(RW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_mem_re(re), .mem_mem_we(we), .mem_mem_addr(addr), .mem_store_data(sdata),
    .mem_regfile_we(rf_we), .mem_regfile_waddr(waddr), .mem_data(mdata),
    .dmem(bus.master),
    .stall_o(stall_o), .wb_regfile_we(wb_regfile_we), .wb_regfile_waddr(wb_regfile_waddr),
    .wb_data(wb_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst, re, we, rf_we, gnt, rvalid;
    logic [AW-1:0] addr;
    logic [DW-1:0] sdata, mdata, rdata;
    logic [RW-1:0] waddr;
    logic          e_stall, e_req, e_err;
    logic          chk_wb, e_wb_we;
    logic [RW-1:0] e_wb_waddr;
    logic [DW-1:0] e_wb_data;
    logic          chk_dmem, e_dwe;
    logic [AW-1:0] e_daddr;
    logic [DW-1:0] e_dwdata;
  } cyc_t;

  cyc_t sch[$];

  // writeback registers as they will be visible in the next cycle appended
  logic          vis_we;
  logic [RW-1:0] vis_waddr;
  logic [DW-1:0] vis_data;

  int pin_alu = -1, ld_start = -1, st_start = -1, pin_both = -1;
  int n_vec = 0, n_err = 0;
  int cur = 0;
  bit run = 0;

  function automatic logic rb(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  // a cycle whose pipeline inputs are don't-care and bus strobes are random noise
  function automatic cyc_t noise();
    cyc_t c;
    c.rst = 1'b0; c.re = rb(50); c.we = rb(50); c.rf_we = rb(50);
    c.gnt = rb(25); c.rvalid = rb(25);
    c.addr = $urandom; c.sdata = $urandom; c.mdata = $urandom; c.rdata = $urandom;
    c.waddr = RW'($urandom);
    c.e_stall = 1'b0; c.e_req = 1'b0; c.e_err = 1'b0;
    c.chk_wb = 1'b1; c.e_wb_we = 1'b0; c.e_wb_waddr = '0; c.e_wb_data = '0;
    c.chk_dmem = 1'b0; c.e_dwe = 1'b0; c.e_daddr = '0; c.e_dwdata = '0;
    return c;
  endfunction

  task automatic emit(input cyc_t c);
    c.e_wb_we = vis_we; c.e_wb_waddr = vis_waddr; c.e_wb_data = vis_data;
    sch.push_back(c);
  endtask

  task automatic gen_alu(input logic a_rfwe, input logic [RW-1:0] a_wa, input logic [DW-1:0] a_d);
    cyc_t c;
    c = noise();
    c.re = 1'b0; c.we = 1'b0; c.rf_we = a_rfwe; c.waddr = a_wa; c.mdata = a_d;
    emit(c);
    vis_we = a_rfwe; vis_waddr = a_wa; vis_data = a_d;
  endtask

  // g = cycles of request before the grant cycle, r = cycles from grant to rvalid
  task automatic gen_access(input logic a_re, input logic a_we, input logic [AW-1:0] a_addr,
                            input logic [DW-1:0] a_sd, input logic a_rfwe, input logic [RW-1:0] a_wa,
                            input logic [DW-1:0] a_rd, input int g, input int r);
    cyc_t c;
    c = noise();
    c.re = a_re; c.we = a_we; c.addr = a_addr; c.sdata = a_sd; c.rf_we = a_rfwe; c.waddr = a_wa;
    c.e_stall = 1'b1;
    emit(c);
    vis_we = 1'b0;
    for (int i = 0; i <= g; i++) begin
      c = noise();
      c.gnt = (i == g);
      c.e_stall = 1'b1; c.e_req = 1'b1;
      c.chk_dmem = 1'b1; c.e_dwe = a_we; c.e_daddr = a_addr; c.e_dwdata = a_sd;
      emit(c);
    end
    if (!a_we) begin
      for (int j = 1; j <= r; j++) begin
        c = noise();
        c.rvalid = (j == r);
        if (j == r) c.rdata = a_rd;
        c.e_stall = 1'b1;
        emit(c);
      end
      vis_we = a_rfwe; vis_waddr = a_wa; vis_data = a_rd;
    end
    c = noise();
    emit(c);
    vis_we = 1'b0;
  endtask

  task automatic gen_reset_in_wait();
    cyc_t c;
    c = noise();
    c.re = 1'b1; c.we = 1'b0; c.rf_we = 1'b1; c.addr = 32'h100; c.waddr = 5'd9;
    c.e_stall = 1'b1;
    emit(c);
    vis_we = 1'b0;
    c = noise(); c.gnt = 1'b1; c.e_stall = 1'b1; c.e_req = 1'b1;
    c.chk_dmem = 1'b1; c.e_dwe = 1'b0; c.e_daddr = 32'h100; c.e_dwdata = c.sdata;
    c.e_dwdata = sch[sch.size()-1].sdata;
    emit(c);
    c = noise(); c.rvalid = 1'b0; c.e_stall = 1'b1;
    emit(c);
    c = noise(); c.rst = 1'b1; c.rvalid = 1'b0;
    emit(c);
    vis_we = 1'b0; vis_waddr = '0; vis_data = '0;
    c = noise();
    c.re = 1'b0; c.we = 1'b0; c.rf_we = 1'b1; c.waddr = 5'd12; c.mdata = 32'hCAFE0001;
    c.rvalid = 1'b1; c.gnt = 1'b1; c.rdata = 32'hBAD0BAD0;
    c.chk_dmem = 1'b1;
    emit(c);
    vis_we = 1'b1; vis_waddr = 5'd12; vis_data = 32'hCAFE0001;
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic gen_timeout();
    cyc_t c;
    c = noise();
    c.re = 1'b1; c.we = 1'b0; c.rf_we = 1'b1; c.addr = 32'h200; c.waddr = 5'd7;
    c.e_stall = 1'b1;
    emit(c);
    vis_we = 1'b0;
    for (int i = 1; i <= TO; i++) begin
      c = noise(); c.gnt = 1'b0;
      c.e_stall = 1'b1; c.e_req = (i < TO); c.e_err = (i == TO);
      emit(c);
    end
    vis_data = '0;
    c = noise();
    emit(c);
  endtask
`endif

  task automatic build();
    cyc_t c;
    c = noise(); c.rst = 1'b1; c.chk_wb = 1'b0;
    emit(c);
    vis_we = 1'b0; vis_waddr = '0; vis_data = '0;
    c = noise(); c.rst = 1'b1; c.chk_dmem = 1'b1;
    emit(c);
    pin_alu = sch.size() + 1;
    gen_alu(1'b1, 5'd5, 32'h1234);
    ld_start = sch.size();
    gen_access(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 5'd3, 32'hDEADBEEF, 0, 2);
    st_start = sch.size();
    gen_access(1'b0, 1'b1, 32'h80, 32'hA5A5A5A5, 1'b0, 5'd1, 32'h0, 3, 1);
    pin_both = sch.size() + 1;
    gen_access(1'b1, 1'b1, 32'hC4, 32'h0F0F0F0F, 1'b1, 5'd8, 32'h0, 1, 1);
    gen_alu(1'b1, 5'd2, 32'h55AA);
    gen_reset_in_wait();
`ifdef MEM_TIMEOUT_EN
    gen_timeout();
`endif
    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 3))
        0: gen_alu(rb(60), RW'($urandom), $urandom);
        1: gen_access(1'b1, 1'b0, $urandom, $urandom, rb(70), RW'($urandom), $urandom,
                      $urandom_range(0, 3), $urandom_range(1, 3));
        2: gen_access(1'b0, 1'b1, $urandom, $urandom, rb(50), RW'($urandom), $urandom,
                      $urandom_range(0, 3), 1);
        default: gen_access(1'b1, 1'b1, $urandom, $urandom, rb(50), RW'($urandom), $urandom,
                            $urandom_range(0, 3), 1);
      endcase
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cur, act, exp);
    end
  endtask

  cyc_t e;
  int ld_stalls = 0, st_reqs = 0;

  // compare DUT outputs against the timeline model away from the active edge
  always @(negedge clk) begin
    if (run) begin
      e = sch[cur];
      chk("stall_o", 32'(stall_o), 32'(e.e_stall));
      chk("dmem_req", 32'(bus.dmem_req), 32'(e.e_req));
      chk("mem_err", 32'(mem_err), 32'(e.e_err));
      if (e.chk_wb) begin
        chk("wb_regfile_we", 32'(wb_regfile_we), 32'(e.e_wb_we));
        chk("wb_regfile_waddr", 32'(wb_regfile_waddr), 32'(e.e_wb_waddr));
        chk("wb_data", wb_data, e.e_wb_data);
      end
      if (e.chk_dmem) begin
        chk("dmem_we", 32'(bus.dmem_we), 32'(e.e_dwe));
        chk("dmem_addr", bus.dmem_addr, e.e_daddr);
        chk("dmem_wdata", bus.dmem_wdata, e.e_dwdata);
      end
      if (cur == pin_alu) begin
        chk("pin_alu_data", wb_data, 32'h1234);
        chk("pin_alu_waddr", 32'(wb_regfile_waddr), 32'd5);
      end
      if (cur == ld_start + 1) chk("pin_load_addr", bus.dmem_addr, 32'h40);
      if (cur >= ld_start && cur <= ld_start + 4 && stall_o) ld_stalls++;
      if (cur == ld_start + 4) begin
        chk("pin_load_stall_cycles", 32'(ld_stalls), 32'd4);
        chk("pin_load_wb_data", wb_data, 32'hDEADBEEF);
        chk("pin_load_wb_we", 32'(wb_regfile_we), 32'd1);
        chk("pin_load_wb_waddr", 32'(wb_regfile_waddr), 32'd3);
      end
      if (cur >= st_start && cur <= st_start + 5 && bus.dmem_req) st_reqs++;
      if (cur == st_start + 4) chk("pin_store_wdata", bus.dmem_wdata, 32'hA5A5A5A5);
      if (cur == st_start + 5) begin
        chk("pin_store_req_cycles", 32'(st_reqs), 32'd4);
        chk("pin_store_resp_stall", 32'(stall_o), 32'd0);
      end
      if (cur == pin_both) chk("pin_both_is_store", 32'(bus.dmem_we), 32'd1);
    end
  end

  initial begin
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
    build();
    for (int i = 0; i < sch.size(); i++) begin
      @(posedge clk);
      #1;
      rst = sch[i].rst; re = sch[i].re; we = sch[i].we; addr = sch[i].addr;
      sdata = sch[i].sdata; rf_we = sch[i].rf_we; waddr = sch[i].waddr; mdata = sch[i].mdata;
      bus.dmem_gnt = sch[i].gnt; bus.dmem_rvalid = sch[i].rvalid; bus.dmem_rdata = sch[i].rdata;
      cur = i;
      run = 1;
    end
    @(posedge clk);
    run = 0;
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cur);
    $fatal(1);
  end

endmodule
